mux_n_1_scan: RTL and testbench
===============================

Name: mux_n_1_scan

Overview:
Parametrised, registered N:1 channel selector for the board I/O path. It is the successor to the combinational 2:1 switch-to-LED mux.
- Selects one WIDTH-bit channel from a packed switch bus and drives it to the LEDs.
- Channel index steps on KEY0 presses or on a timed auto-scan.
- Supports an output hold (freeze).

Parameters:
WIDTH, 4, bits per channel (>=1)
CHANNELS, 2, number of input channels (>=2, need not be a power of two)
SCAN_DIV, 50000000, auto-scan dwell in clock cycles per channel (>=1)
DEB_CYCLES, 1000000, debounce stability window in cycles (used only with DEBOUNCE_EN)

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge; the block's single clock
RESET_N  in  1  synchronous, active-low reset
SW  in  WIDTH*CHANNELS  packed channels; channel c = SW[c*WIDTH +: WIDTH]
KEY0  in  1  active-low pushbutton (asynchronous); each press steps the channel
SCAN  in  1  1 = auto-scan enabled
HOLD  in  1  1 = freeze LEDR
LEDR  out  WIDTH  registered selected channel
SEL  out  SELW  current channel index; SELW = max(1, clog2(CHANNELS))

Behaviour:
- Reset (RESET_N=0 at a rising edge):
  - SEL=0, LEDR=0, dwell counter=0.
  - KEY0 synchroniser flops k_s1, k_s2 and k_prev all cleared to 0, meaning "pressed". This prevents a spurious press after reset.
- Reset applies on the next edge even mid-scan or mid-press; there is no partial state.
- Key path:
  - k_s1<=KEY0; k_s2<=k_s1; k_prev<=key_state.
  - key_state = k_s2, or the debounced state with DEBOUNCE_EN.
  - press = k_prev & ~key_state: a one-cycle pulse on each 1->0 transition.
- Press timing, no debounce: KEY0 sampled low at edge E1 gives the press pulse after E2. SEL updates at E3; LEDR shows the new channel at E4.
- A key held low through reset release produces no press. Release followed by a new press produces exactly one press.
- Step rule: advance = press OR tick.
  - On advance: SEL <= (SEL==CHANNELS-1) ? 0 : SEL+1.
  - SEL never exceeds CHANNELS-1.
- Auto-scan:
  - SCAN=1: the dwell counter increments each cycle. When it equals SCAN_DIV-1: tick=1 and the counter returns to 0.
  - SCAN=0: the counter is forced to 0 and tick=0.
  - SCAN_DIV=1: tick every cycle.
- Simultaneous press and tick in the same cycle:
  - SEL advances by exactly one.
  - The counter restarts at 0.
  - Any press in scan mode also restarts the counter, giving a full dwell after a manual step.
- Output:
  - HOLD=0: LEDR <= SW slice of the current SEL every edge (one-cycle latency from SW and from SEL).
  - HOLD=1: LEDR retains its value; SEL and the counter keep operating.
  - When HOLD falls, LEDR reflects the current SEL channel at the next edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
Macro: MUX_N_1_SCAN_DEBOUNCE_EN
- Defined:
  - Debounced state `deb` resets to 0.
  - Counter `dcnt` counts consecutive cycles where k_s2 != deb, and clears to 0 whenever k_s2 == deb.
  - When dcnt reaches DEB_CYCLES-1 with k_s2 still != deb: deb <= k_s2 and dcnt <= 0.
  - key_state = deb.
  - Press latency grows by DEB_CYCLES cycles.
  - Bounces shorter than DEB_CYCLES are ignored.
- Undefined:
  - key_state = k_s2.
  - No debounce logic is generated; DEB_CYCLES is unused.

Test Plan:
Bench parameters: WIDTH=4, CHANNELS=3, SCAN_DIV=5, DEB_CYCLES=4. SW=12'hABC (ch0=C, ch1=B, ch2=A).
1. Reset check: hold RESET_N=0 for 3 edges, then release with KEY0=1 -> LEDR=0 and SEL=0 during reset; LEDR=4'hC one edge after release.
2. Manual step: three KEY0 presses (low 6 cycles, high 6 cycles) -> SEL 1,2,0 and LEDR B,A,C. SEL changes at the 3rd edge after KEY0 is sampled low; LEDR changes one edge later.
3. Auto-scan: SCAN=1 -> SEL advances every 5 cycles, wrapping 2->0. A press pulse coinciding with a tick gives a single advance, and the next tick comes 5 cycles later.
4. Hold: HOLD=1, change SW to 12'h123 and press once -> LEDR stays at its old value while SEL advances. Drop HOLD -> LEDR equals the new channel's value at the next edge.
5. Reset with key held: KEY0=0 held through the reset deassertion for 10 cycles -> SEL stays 0, no press. Release and press once -> SEL=1.
6. Debounce (with MUX_N_1_SCAN_DEBOUNCE_EN): a KEY0 low glitch of 3 cycles -> no step. KEY0 low for 8 cycles -> exactly one step, DEB_CYCLES cycles later than the non-debounced timing.

Source files
------------

// File: rtl/mux_n_1_scan_if.sv
// Bus bundle for mux_n_1_scan.
// Inputs: SW (packed channels), KEY0, SCAN, HOLD.
// Outputs: LEDR (selected channel), SEL (channel index).
// master = board/stimulus side, slave = selector.
interface mux_n_1_scan_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2
);
    localparam int SELW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

    logic [WIDTH*CHANNELS-1:0] SW;
    logic                      KEY0;
    logic                      SCAN;
    logic                      HOLD;
    logic [WIDTH-1:0]          LEDR;
    logic [SELW-1:0]           SEL;

    modport master (
        output SW, KEY0, SCAN, HOLD,
        input  LEDR, SEL
    );

    modport slave (
        input  SW, KEY0, SCAN, HOLD,
        output LEDR, SEL
    );
endinterface

// File: rtl/mux_n_1_scan.sv
// Registered N:1 channel selector, stepped by KEY0 or auto-scan.
// Ports: CLOCK_50, RESET_N (sync, active-low), bus (slave):
//   SW/KEY0/SCAN/HOLD in, LEDR/SEL out.
// Optional: MUX_N_1_SCAN_DEBOUNCE_EN adds a KEY0 debouncer.
module mux_n_1_scan #(
    parameter int WIDTH      = 4,
    parameter int CHANNELS   = 2,
    parameter int SCAN_DIV   = 50000000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic          CLOCK_50,
    input  logic          RESET_N,
    mux_n_1_scan_if.slave bus
);
    localparam int SELW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
    localparam int CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SELW-1:0] SEL_LAST = SELW'(CHANNELS - 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SCAN_DIV - 1);

    if (WIDTH < 1 || CHANNELS < 2 || SCAN_DIV < 1 || DEB_CYCLES < 1)
    begin : g_param_chk
        $error("mux_n_1_scan: parameter out of range");
    end

    logic            k_s1;
    logic            k_s2;
    logic            k_prev;
    logic            key_state;
    logic            press;
    logic            tick;
    logic            advance;
    logic [CW-1:0]   cnt;
    logic [SELW-1:0] sel;
    logic [WIDTH-1:0] chan;
    logic [WIDTH-1:0] ledr;

    // Sync flops clear to "pressed" so a key already down at
    // reset release never looks like a fresh press.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            k_s1   <= 1'b0;
            k_s2   <= 1'b0;
            k_prev <= 1'b0;
        end else begin
            k_s1   <= bus.KEY0;
            k_s2   <= k_s1;
            k_prev <= key_state;
        end
    end

`ifdef MUX_N_1_SCAN_DEBOUNCE_EN
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          deb;
    logic [DW-1:0] dcnt;

    // deb follows k_s2 only after DEB_CYCLES consecutive
    // disagreeing samples; any agreement restarts the window.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            deb  <= 1'b0;
            dcnt <= '0;
        end else if (k_s2 == deb) begin
            dcnt <= '0;
        end else if (dcnt == DEB_LAST) begin
            deb  <= k_s2;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    assign key_state = deb;
`else
    assign key_state = k_s2;
`endif

    assign press   = k_prev & ~key_state;
    assign tick    = bus.SCAN && (cnt == CNT_LAST);
    assign advance = press | tick;

    // A manual step restarts the dwell so the new channel
    // gets a full scan period.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            cnt <= '0;
        end else if (!bus.SCAN || advance) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sel <= '0;
        end else if (advance) begin
            sel <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
        end
    end

    always_comb begin
        chan = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sel == SELW'(c)) begin
                chan = bus.SW[c*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            ledr <= '0;
        end else if (!bus.HOLD) begin
            ledr <= chan;
        end
    end

    assign bus.SEL  = sel;
    assign bus.LEDR = ledr;
endmodule

// File: tb/tb_mux_n_1_scan.sv
// Self-checking bench for mux_n_1_scan: table vectors, timed
// sequences and random traffic against a history-based model.
`timescale 1ns/1ps
module tb_mux_n_1_scan;
    localparam int WIDTH      = 4;
    localparam int CHANNELS   = 3;
    localparam int SCAN_DIV   = 5;
    localparam int DEB_CYCLES = 4;
`ifdef MUX_N_1_SCAN_DEBOUNCE_EN
    localparam int D = DEB_CYCLES;
`else
    localparam int D = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mux_n_1_scan_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    mux_n_1_scan #(
        .WIDTH     (WIDTH),
        .CHANNELS  (CHANNELS),
        .SCAN_DIV  (SCAN_DIV),
        .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: keeps per-edge histories of KEY0 samples
    // and of the resolved key level; a step happens one edge
    // after the resolved level falls.
    bit         smp [16];
    bit         kst [16];
    int         m_sel;
    int         m_dwell;
    logic [3:0] m_led;
    bit         m_deb;
    bit         m_live = 1'b0;

    function automatic logic [3:0] chan_of(input logic [11:0] sw,
                                           input int c);
        return 4'((sw >> (c * WIDTH)) & 12'hF);
    endfunction

    always @(posedge clk) begin
        bit pr;
        bit tk;
        bit nk;
        bit flip;
        if (!rst_n) begin
            foreach (smp[i]) begin
                smp[i] = 1'b0;
                kst[i] = 1'b0;
            end
            m_sel   = 0;
            m_dwell = 0;
            m_led   = '0;
            m_deb   = 1'b0;
            m_live  = 1'b1;
        end else if (m_live) begin
            pr = kst[1] && !kst[0];
            tk = bus.SCAN && (m_dwell == SCAN_DIV - 1);
            if (!bus.HOLD) m_led = chan_of(bus.SW, m_sel);
            if (pr || tk) m_sel = (m_sel + 1) % CHANNELS;
            if (!bus.SCAN || pr || tk) m_dwell = 0;
            else m_dwell++;
            if (D == 0) begin
                nk = smp[0];
            end else begin
                flip = 1'b1;
                for (int i = 1; i <= D; i++)
                    if (smp[i] == m_deb) flip = 1'b0;
                if (flip) m_deb = !m_deb;
                nk = m_deb;
            end
            for (int i = 15; i > 0; i--) begin
                smp[i] = smp[i-1];
                kst[i] = kst[i-1];
            end
            smp[0] = bus.KEY0;
            kst[0] = nk;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("model_sel", 32'(bus.SEL), m_sel);
            check("model_led", 32'(bus.LEDR), 32'(m_led));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key();
        bus.KEY0 = 1'b0;
        cyc(6);
        bus.KEY0 = 1'b1;
        cyc(6);
    endtask

    typedef struct {
        bit         press;
        bit         hold;
        logic [11:0] sw;
        int         idle;
        int         sel;
        logic [3:0] led;
    } vec_t;

    vec_t tbl [6];
    int   es;
    int   run;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 12'hABC, 0, 1, 4'hB};
        tbl[1] = '{1'b1, 1'b0, 12'hABC, 0, 2, 4'hA};
        tbl[2] = '{1'b1, 1'b0, 12'hABC, 0, 0, 4'hC};
        tbl[3] = '{1'b1, 1'b1, 12'h123, 0, 1, 4'hC};
        tbl[4] = '{1'b0, 1'b0, 12'h123, 1, 1, 4'h2};
        tbl[5] = '{1'b1, 1'b0, 12'hABC, 0, 2, 4'hA};

        rst_n    = 1'b0;
        bus.KEY0 = 1'b1;
        bus.SCAN = 1'b0;
        bus.HOLD = 1'b0;
        bus.SW   = 12'hABC;

        cyc(3);
        check("rst_sel", 32'(bus.SEL), 0);
        check("rst_led", 32'(bus.LEDR), 0);
        rst_n = 1'b1;
        cyc(1);
        check("rel_led", 32'(bus.LEDR), 32'hC);
        check("rel_sel", 32'(bus.SEL), 0);

        for (int i = 0; i < 6; i++) begin
            bus.SW   = tbl[i].sw;
            bus.HOLD = tbl[i].hold;
            if (tbl[i].press) press_key();
            else cyc(tbl[i].idle);
            check("tbl_sel", 32'(bus.SEL), tbl[i].sel);
            check("tbl_led", 32'(bus.LEDR), 32'(tbl[i].led));
        end

        bus.KEY0 = 1'b0;
        cyc(2 + D);
        check("pt_sel_pre", 32'(bus.SEL), 2);
        cyc(1);
        check("pt_sel_step", 32'(bus.SEL), 0);
        check("pt_led_pre", 32'(bus.LEDR), 32'hA);
        cyc(1);
        check("pt_led_step", 32'(bus.LEDR), 32'hC);
        bus.KEY0 = 1'b1;
        cyc(8);
        es = 0;

`ifdef MUX_N_1_SCAN_DEBOUNCE_EN
        bus.KEY0 = 1'b0;
        cyc(3);
        bus.KEY0 = 1'b1;
        cyc(8);
        check("deb_glitch", 32'(bus.SEL), es);
        bus.KEY0 = 1'b0;
        cyc(8);
        bus.KEY0 = 1'b1;
        cyc(8);
        es = (es + 1) % CHANNELS;
        check("deb_press", 32'(bus.SEL), es);
`endif

        bus.SCAN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(SCAN_DIV - 1);
            check("scan_dwell", 32'(bus.SEL), es);
            cyc(1);
            es = (es + 1) % CHANNELS;
            check("scan_tick", 32'(bus.SEL), es);
        end
        cyc(7 - D);
        bus.KEY0 = 1'b0;
        cyc(2 + D);
        es = (es + 1) % CHANNELS;
        check("co_pre", 32'(bus.SEL), es);
        cyc(1);
        es = (es + 1) % CHANNELS;
        check("co_single", 32'(bus.SEL), es);
        bus.KEY0 = 1'b1;
        cyc(4);
        check("co_dwell", 32'(bus.SEL), es);
        cyc(1);
        es = (es + 1) % CHANNELS;
        check("co_next", 32'(bus.SEL), es);
        bus.SCAN = 1'b0;
        cyc(8);

        bus.KEY0 = 1'b0;
        rst_n    = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(10);
        check("rk_hold", 32'(bus.SEL), 0);
        bus.KEY0 = 1'b1;
        cyc(8);
        check("rk_release", 32'(bus.SEL), 0);
        press_key();
        check("rk_press", 32'(bus.SEL), 1);
        check("rk_led", 32'(bus.LEDR), 32'hB);

        run = 0;
        for (int n = 0; n < 600; n++) begin
            if (run == 0) begin
                bus.KEY0 = 1'($urandom_range(0, 1));
                run = $urandom_range(1, 10);
            end
            run--;
            if ($urandom_range(0, 15) == 0) bus.SCAN = ~bus.SCAN;
            if ($urandom_range(0, 7) == 0) bus.HOLD = ~bus.HOLD;
            if ($urandom_range(0, 3) == 0) bus.SW = 12'($urandom);
            rst_n = ($urandom_range(0, 199) != 0);
            cyc(1);
        end
        rst_n = 1'b1;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
